// File: rtl/m_seq_pkg.sv
// State encoding, funct3 codes and select constants for the M-extension sequencer.
package m_seq_pkg;

`include "m_definitions.svh"

    localparam int MUX_A_LENGTH = `MUX_A_LENGTH;
    localparam int MUX_B_LENGTH = `MUX_B_LENGTH;
    localparam int MUX_R_LENGTH = `MUX_R_LENGTH;
    localparam int MUX_D_LENGTH = `MUX_D_LENGTH;
    localparam int MUX_Z_LENGTH = `MUX_Z_LENGTH;

    localparam logic [MUX_A_LENGTH-1:0] MUX_A_KEEP       = `MUX_A_KEEP;
    localparam logic [MUX_A_LENGTH-1:0] MUX_A_R_SIGNED   = `MUX_A_R_SIGNED;
    localparam logic [MUX_A_LENGTH-1:0] MUX_A_R_UNSIGNED = `MUX_A_R_UNSIGNED;
    localparam logic [MUX_B_LENGTH-1:0] MUX_B_KEEP       = `MUX_B_KEEP;
    localparam logic [MUX_B_LENGTH-1:0] MUX_B_D_SIGNED   = `MUX_B_D_SIGNED;
    localparam logic [MUX_B_LENGTH-1:0] MUX_B_D_UNSIGNED = `MUX_B_D_UNSIGNED;
    localparam logic [MUX_R_LENGTH-1:0] MUX_R_KEEP       = `MUX_R_KEEP;
    localparam logic [MUX_R_LENGTH-1:0] MUX_R_A          = `MUX_R_A;
    localparam logic [MUX_R_LENGTH-1:0] MUX_R_A_NEG      = `MUX_R_A_NEG;
    localparam logic [MUX_R_LENGTH-1:0] MUX_R_MULT_LOWER = `MUX_R_MULT_LOWER;
    localparam logic [MUX_R_LENGTH-1:0] MUX_R_SUB_KEEP   = `MUX_R_SUB_KEEP;
    localparam logic [MUX_D_LENGTH-1:0] MUX_D_KEEP       = `MUX_D_KEEP;
    localparam logic [MUX_D_LENGTH-1:0] MUX_D_B          = `MUX_D_B;
    localparam logic [MUX_D_LENGTH-1:0] MUX_D_B_NEG      = `MUX_D_B_NEG;
    localparam logic [MUX_D_LENGTH-1:0] MUX_D_SHR        = `MUX_D_SHR;
    localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_KEEP       = `MUX_Z_KEEP;
    localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_ZERO       = `MUX_Z_ZERO;
    localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_MULT_UPPER = `MUX_Z_MULT_UPPER;
    localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_SHL_ADD    = `MUX_Z_SHL_ADD;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_LOAD        = 3'd1,
        S_MUL_ISSUE   = 3'd2,
        S_MUL_WAIT    = 3'd3,
        S_MUL_CAPTURE = 3'd4,
        S_DIV_ITER    = 3'd5,
        S_DONE        = 3'd6
    } m_state_e;

    // Result lives in Z for high-half products and quotients, in R otherwise.
    function automatic logic res_sel_f(input logic [2:0] f3);
        logic sel;
        case (f3)
            F3_MUL, F3_REM, F3_REMU:                      sel = 1'b0;
            F3_MULH, F3_MULHSU, F3_MULHU, F3_DIV, F3_DIVU: sel = 1'b1;
            default:                                      sel = 1'b0;
        endcase
        return sel;
    endfunction

    // Divide-by-zero quotient stays all-ones, so its sign fix is suppressed.
    function automatic logic res_neg_f(input logic [2:0] f3, input logic s1,
                                       input logic s2, input logic z);
        logic neg;
        case (f3)
            F3_DIV:  neg = (s1 ^ s2) & ~z;
            F3_REM:  neg = s1;
            default: neg = 1'b0;
        endcase
        return neg;
    endfunction

endpackage

// File: rtl/m_definitions.svh
// Shared select encodings and widths for the M-extension datapath muxes.
`ifndef M_DEFINITIONS_SVH
`define M_DEFINITIONS_SVH

`define MUX_A_LENGTH       2
`define MUX_A_KEEP         2'd0
`define MUX_A_R_SIGNED     2'd1
`define MUX_A_R_UNSIGNED   2'd2

`define MUX_B_LENGTH       2
`define MUX_B_KEEP         2'd0
`define MUX_B_D_SIGNED     2'd1
`define MUX_B_D_UNSIGNED   2'd2

`define MUX_R_LENGTH       3
`define MUX_R_KEEP         3'd0
`define MUX_R_A            3'd1
`define MUX_R_A_NEG        3'd2
`define MUX_R_MULT_LOWER   3'd3
`define MUX_R_SUB_KEEP     3'd4

`define MUX_D_LENGTH       2
`define MUX_D_KEEP         2'd0
`define MUX_D_B            2'd1
`define MUX_D_B_NEG        2'd2
`define MUX_D_SHR          2'd3

`define MUX_Z_LENGTH       2
`define MUX_Z_KEEP         2'd0
`define MUX_Z_ZERO         2'd1
`define MUX_Z_MULT_UPPER   2'd2
`define MUX_Z_SHL_ADD      2'd3

`endif

// File: rtl/m_sequencer.sv
// Control FSM for the RV32M multiply/divide datapath: drives the register-bank
// selects cycle by cycle and tells writeback where the result is and its sign.
module m_sequencer
    import m_seq_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic                    flush,
    input  logic [2:0]              funct3,
    input  logic                    rs1_sign,
    input  logic                    rs2_sign,
    input  logic                    rs2_zero,
    input  logic                    sub_neg,
    output logic [MUX_A_LENGTH-1:0] mux_A,
    output logic [MUX_B_LENGTH-1:0] mux_B,
    output logic [MUX_R_LENGTH-1:0] mux_R,
    output logic [MUX_D_LENGTH-1:0] mux_D,
    output logic [MUX_Z_LENGTH-1:0] mux_Z,
    output logic                    busy,
    output logic                    done,
    output logic                    result_sel,
    output logic                    result_neg
);

    localparam logic [2:0] WAIT_LAST = 3'(MUL_LAT - 1);
    localparam logic [5:0] DIV_LAST  = 6'd31;

    m_state_e state_r, state_s;
    logic [2:0] f3_r;
    logic       s1_r, s2_r;
    logic [2:0] wait_cnt_r;
    logic [5:0] div_cnt_r;
    logic       accept_s, signed_div_s;
    logic [MUX_A_LENGTH-1:0] mul_a_s;
    logic [MUX_B_LENGTH-1:0] mul_b_s;
    logic       unused_s;

    // sub_neg is only observed by external checkers; the FSM timing is fixed.
    assign unused_s     = sub_neg;
    assign accept_s     = (state_r == S_IDLE) & start & ~flush;
    assign signed_div_s = f3_r[2] & ~f3_r[0];
    assign mul_a_s = ((f3_r == F3_MULH) || (f3_r == F3_MULHSU)) ? MUX_A_R_SIGNED : MUX_A_R_UNSIGNED;
    assign mul_b_s = (f3_r == F3_MULH) ? MUX_B_D_SIGNED : MUX_B_D_UNSIGNED;

    // State register, operation latch and registered writeback routing.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r    <= S_IDLE;
            f3_r       <= 3'd0;
            s1_r       <= 1'b0;
            s2_r       <= 1'b0;
            result_sel <= 1'b0;
            result_neg <= 1'b0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                f3_r       <= funct3;
                s1_r       <= rs1_sign;
                s2_r       <= rs2_sign;
                result_sel <= res_sel_f(funct3);
                result_neg <= res_neg_f(funct3, rs1_sign, rs2_sign, rs2_zero);
            end
        end
    end

    // Phase counters run only while the FSM stays in their state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wait_cnt_r <= 3'd0;
            div_cnt_r  <= 6'd0;
        end else begin
            wait_cnt_r <= ((state_r == S_MUL_WAIT) && (state_s == S_MUL_WAIT)) ? wait_cnt_r + 3'd1 : 3'd0;
            div_cnt_r  <= ((state_r == S_DIV_ITER) && (state_s == S_DIV_ITER)) ? div_cnt_r + 6'd1 : 6'd0;
        end
    end

    // Next-state decode; flush overrides every other transition.
    always_comb begin
        state_s = state_r;
        if (flush) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE:        state_s = start ? S_LOAD : S_IDLE;
                S_LOAD:        state_s = f3_r[2] ? S_DIV_ITER : S_MUL_ISSUE;
                S_MUL_ISSUE:   state_s = S_MUL_WAIT;
                S_MUL_WAIT:    state_s = (wait_cnt_r == WAIT_LAST) ? S_MUL_CAPTURE : S_MUL_WAIT;
                S_MUL_CAPTURE: state_s = S_DONE;
                S_DIV_ITER:    state_s = (div_cnt_r == DIV_LAST) ? S_DONE : S_DIV_ITER;
                S_DONE:        state_s = S_IDLE;
                default:       state_s = S_IDLE;
            endcase
        end
    end

    // Select decode; multiplier operand selects stay fixed through capture.
    always_comb begin
        mux_A = MUX_A_KEEP;
        mux_B = MUX_B_KEEP;
        mux_R = MUX_R_KEEP;
        mux_D = MUX_D_KEEP;
        mux_Z = MUX_Z_KEEP;
        busy  = (state_r != S_IDLE);
        done  = (state_r == S_DONE);
        case (state_r)
            S_LOAD: begin
                mux_Z = MUX_Z_ZERO;
                if (signed_div_s && s1_r) mux_R = MUX_R_A_NEG;
                else                      mux_R = MUX_R_A;
                if (signed_div_s && s2_r) mux_D = MUX_D_B_NEG;
                else                      mux_D = MUX_D_B;
            end
            S_MUL_ISSUE, S_MUL_WAIT: begin
                mux_A = mul_a_s;
                mux_B = mul_b_s;
            end
            S_MUL_CAPTURE: begin
                mux_A = mul_a_s;
                mux_B = mul_b_s;
                mux_R = MUX_R_MULT_LOWER;
                mux_Z = MUX_Z_MULT_UPPER;
            end
            S_DIV_ITER: begin
                mux_R = MUX_R_SUB_KEEP;
                mux_Z = MUX_Z_SHL_ADD;
                mux_D = MUX_D_SHR;
            end
            default: begin
            end
        endcase
    end

endmodule
